// File: rtl/rs_decode_seq.sv
// rs_decode_seq: stream-side sequencer for the RS decoder core (load, clear, decode, replay).
// Optional decode-phase watchdog is enabled by defining RS_DECODE_SEQ_TIMEOUT_EN.
module rs_decode_seq #(
  parameter int NWORDS  = 50,
  parameter int DW      = 32,
  parameter int TMO_CYC = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DW-1:0]        in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DW-1:0]        out_data_o,
  output logic                 out_last_o,
  output logic                 out_err_o,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic                 dec_clrn_o,
  output logic                 dec_en_o,
  output logic [NWORDS*DW-1:0] dec_data_o,
  input  logic                 dec_ready_i,
  input  logic                 dec_valid_i,
  input  logic                 dec_err_i,
  input  logic [NWORDS*DW-1:0] dec_pos_i
);
  // state | meaning
  // IDLE  | waiting for the first codeword word
  // LOAD  | collecting the remaining codeword words
  // CLR   | one-cycle active-low decoder clear
  // START | waiting for the decoder to report ready
  // RUN   | decoder enabled until output_valid
  // DRAIN | replaying the captured error positions

  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLR, S_START, S_RUN, S_DRAIN} state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [NWORDS-1:0][DW-1:0] ld_buf_q, res_q;
  logic                      err_q;
  logic                      ld_we, cap_en;
  logic                      wd_hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_we   = 1'b0;
    cap_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          ld_we = 1'b1;
          if (NWORDS == 1) begin
            state_d = S_CLR;
            cnt_d   = '0;
          end else begin
            state_d = S_LOAD;
            cnt_d   = CW'(1);
          end
        end
      end
      S_LOAD: begin
        if (in_valid_i) begin
          ld_we = 1'b1;
          if (cnt_q == LAST) begin
            state_d = S_CLR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_CLR: state_d = S_START;
      S_START: begin
        if (wd_hit) state_d = S_IDLE;
        else if (dec_ready_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (dec_valid_i) begin
          cap_en  = 1'b1;
          state_d = S_DRAIN;
        end else if (wd_hit) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (out_ready_i) begin
          if (cnt_q == LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides any handshake or capture in the same cycle.
    if (abort_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ld_we   = 1'b0;
      cap_en  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ld_buf_q <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ld_we) ld_buf_q[cnt_q] <= in_data_i;
      if (cap_en) begin
        res_q <= dec_pos_i;
        err_q <= dec_err_i;
      end
    end
  end

`ifdef RS_DECODE_SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TMO_CYC + 1);
  logic [WW-1:0] wd_q;
  logic          tmo_q;

  assign wd_hit = ((state_q == S_START) || (state_q == S_RUN)) && (wd_q == WW'(TMO_CYC - 1));

  // START is only ever entered from CLR, so CLR is where the count restarts.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      if (state_q == S_CLR) wd_q <= '0;
      else if ((state_q == S_START) || (state_q == S_RUN)) wd_q <= wd_q + 1'b1;
      if (ld_we) tmo_q <= 1'b0;
      else if (wd_hit && !abort_i && (state_d == S_IDLE)) tmo_q <= 1'b1;
    end
  end

  assign timeout_o = tmo_q;
`else
  assign wd_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign in_ready_o  = rst_ni && ((state_q == S_IDLE) || (state_q == S_LOAD));
  assign busy_o      = (state_q != S_IDLE);
  assign out_valid_o = (state_q == S_DRAIN);
  assign out_last_o  = out_valid_o && (cnt_q == LAST);
  assign out_data_o  = res_q[cnt_q];
  assign out_err_o   = err_q;
  assign dec_clrn_o  = (state_q != S_CLR);
  assign dec_en_o    = (state_q == S_RUN);
  assign dec_data_o  = ld_buf_q;

endmodule

// File: tb/tb_rs_decode_seq.sv
// Self-checking bench for rs_decode_seq with a behavioural decoder model.
// Expected result word k = loaded word k ^ 32'hA5A5_0000.
module tb_rs_decode_seq;
  localparam int NW = 50;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic in_valid_i = 1'b0;
  logic [DW-1:0] in_data_i = '0;
  logic out_ready_i = 1'b0;
  logic abort_i = 1'b0;
  logic dec_ready_i = 1'b1;
  logic dec_valid_i = 1'b0;
  logic dec_err_i = 1'b0;
  logic [NW*DW-1:0] dec_pos_i = '0;
  logic in_ready_o, out_valid_o, out_last_o, out_err_o, busy_o, timeout_o;
  logic dec_clrn_o, dec_en_o;
  logic [DW-1:0] out_data_o;
  logic [NW*DW-1:0] dec_data_o;

  rs_decode_seq #(.NWORDS(NW), .DW(DW), .TMO_CYC(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .out_err_o(out_err_o), .abort_i(abort_i),
    .busy_o(busy_o), .timeout_o(timeout_o), .dec_clrn_o(dec_clrn_o), .dec_en_o(dec_en_o),
    .dec_data_o(dec_data_o), .dec_ready_i(dec_ready_i), .dec_valid_i(dec_valid_i),
    .dec_err_i(dec_err_i), .dec_pos_i(dec_pos_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] sent [NW];
  logic [31:0] got [NW];
  logic got_last [NW];
  logic got_err [NW];
  int dec_delay = 20;
  logic dec_err_cfg = 1'b1;
  bit dec_mute = 1'b0;
  int clrn_lows = 0;
  int cyc = 0;
  int clr_cyc = 0;

  // Decoder model: output_valid a fixed number of enabled cycles after enable rises.
  initial begin
    int en_cnt;
    en_cnt = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      dec_valid_i = 1'b0;
      if (!dec_clrn_o) begin
        clrn_lows++;
        clr_cyc = cyc;
      end
      if (dec_en_o && !dec_mute) begin
        en_cnt++;
        if (en_cnt == dec_delay) begin
          dec_valid_i = 1'b1;
          dec_err_i = dec_err_cfg;
          for (int k = 0; k < NW; k++)
            dec_pos_i[k*DW +: DW] = dec_data_o[k*DW +: DW] ^ 32'hA5A5_0000;
        end
      end else begin
        en_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout sim time limit reached, expected completion");
    $fatal(1, "bench time limit");
  end

  task automatic send_words(input int count, input int gap_pct, output bit ok);
    int i, guard;
    i = 0; guard = 0; ok = 1'b1;
    while (i < count) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin ok = 1'b0; break; end
      in_valid_i = ($urandom_range(0, 99) >= gap_pct);
      in_data_i = sent[i];
      if (in_valid_i && in_ready_o) i++;
    end
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic collect_words(input int count, input bit stall, output int n,
                               output int unstable, output bit ok);
    logic [31:0] held;
    bit pending;
    int guard;
    n = 0; unstable = 0; ok = 1'b1; pending = 1'b0; guard = 0; held = '0;
    while (n < count) begin
      @(negedge clk);
      guard++;
      if (guard > 20000) begin ok = 1'b0; break; end
      if (pending && (!out_valid_o || out_data_o !== held)) unstable++;
      out_ready_i = stall ? (guard % 4 == 0) : 1'b1;
      if (out_valid_o) begin
        if (out_ready_i) begin
          got[n] = out_data_o; got_last[n] = out_last_o; got_err[n] = out_err_o;
          n++; pending = 1'b0;
        end else begin
          pending = 1'b1; held = out_data_o;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    checks++; if (dec_clrn_o !== 1'b1 || dec_en_o !== 1'b0) begin errors++; $display("FAIL rst_dec clrn=%b en=%b exp 1/0", dec_clrn_o, dec_en_o); end
    checks++; if (out_err_o !== 1'b0 || out_last_o !== 1'b0 || timeout_o !== 1'b0) begin errors++; $display("FAIL rst_flags err=%b last=%b tmo=%b exp 0", out_err_o, out_last_o, timeout_o); end
    checks++; if (dec_data_o !== '0) begin errors++; $display("FAIL rst_buffer got=%h exp=0", dec_data_o[31:0]); end
    rst_ni = 1'b1;
    @(negedge clk);
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", in_ready_o); end
  endtask

  task automatic test_basic();
    int n, unst; bit ok;
    for (int k = 0; k < NW; k++) sent[k] = k;
    dec_err_cfg = 1'b1; dec_delay = 20; clrn_lows = 0;
    send_words(NW, 0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_send got=%b exp=1", ok); end
    collect_words(NW, 1'b0, n, unst, ok);
    checks++; if (n !== NW) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", n, NW); end
    for (int k = 0; k < n; k++) begin
      checks++; if (got[k] !== (sent[k] ^ 32'hA5A5_0000)) begin errors++; $display("FAIL basic_word%0d got=%h exp=%h", k, got[k], sent[k] ^ 32'hA5A5_0000); end
      checks++; if (got_last[k] !== (k == NW-1)) begin errors++; $display("FAIL basic_last%0d got=%b exp=%b", k, got_last[k], (k == NW-1)); end
      checks++; if (got_err[k] !== 1'b1) begin errors++; $display("FAIL basic_err%0d got=%b exp=1", k, got_err[k]); end
    end
    checks++; if (clrn_lows !== 1) begin errors++; $display("FAIL basic_clr_pulse got=%0d exp=1", clrn_lows); end
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_end got=%b exp=0", busy_o); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    int n, unst, bad; bit ok;
    for (int k = 0; k < NW; k++) sent[k] = $urandom;
    dec_err_cfg = 1'($urandom_range(0, 1)); dec_delay = 7;
    send_words(NW, 40, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_send got=%b exp=1", ok); end
    collect_words(NW, 1'b1, n, unst, ok);
    checks++; if (n !== NW) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", n, NW); end
    checks++; if (unst !== 0) begin errors++; $display("FAIL bp_stable got=%0d exp=0", unst); end
    bad = 0;
    for (int k = 0; k < n; k++)
      if (got[k] !== (sent[k] ^ 32'hA5A5_0000) || got_err[k] !== dec_err_cfg || got_last[k] !== (k == NW-1)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_words got=%0d bad exp=0", bad); end
    @(negedge clk);
    checks++; if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_busy_end busy=%b valid=%b exp 0/0", busy_o, out_valid_o); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_abort_load();
    int n, unst, bad; bit ok;
    for (int k = 0; k < NW; k++) sent[k] = $urandom;
    send_words(25, 20, ok);
    abort_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    abort_i = 1'b0; in_valid_i = 1'b0;
    checks++; if (busy_o !== 1'b0 || in_ready_o !== 1'b1) begin errors++; $display("FAIL abort_load_idle busy=%b ready=%b exp 0/1", busy_o, in_ready_o); end
    for (int k = 0; k < NW; k++) sent[k] = $urandom;
    dec_err_cfg = 1'b0;
    send_words(NW, 20, ok);
    collect_words(NW, 1'b0, n, unst, ok);
    bad = 0;
    for (int k = 0; k < n; k++) if (got[k] !== (sent[k] ^ 32'hA5A5_0000)) bad++;
    checks++; if (n !== NW || bad !== 0) begin errors++; $display("FAIL abort_load_words n=%0d bad=%0d exp %0d/0", n, bad, NW); end
    checks++; if (got_err[0] !== 1'b0) begin errors++; $display("FAIL abort_load_err got=%b exp=0", got_err[0]); end
    @(negedge clk);
    out_ready_i = 1'b0;
  endtask

  task automatic test_abort_run();
    bit ok, found; int vh;
    for (int k = 0; k < NW; k++) sent[k] = $urandom;
    dec_delay = 5;
    send_words(NW, 0, ok);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (dec_valid_i) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL abort_run_valid_seen got=%b exp=1", found); end
    abort_i = 1'b1; out_ready_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checks++; if (out_valid_o !== 1'b0 || dec_en_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL abort_run_state valid=%b en=%b busy=%b exp 0/0/0", out_valid_o, dec_en_o, busy_o); end
    vh = 0;
    repeat (5) begin @(negedge clk); if (out_valid_o) vh++; end
    checks++; if (vh !== 0) begin errors++; $display("FAIL abort_run_no_output got=%0d exp=0", vh); end
    out_ready_i = 1'b0;
  endtask

`ifdef RS_DECODE_SEQ_TIMEOUT_EN
  task automatic test_watchdog();
    bit ok, hit;
    for (int k = 0; k < NW; k++) sent[k] = $urandom;
    dec_mute = 1'b1;
    send_words(NW, 0, ok);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (timeout_o) hit = 1'b1;
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL wd_fire got=%b exp=1", hit); end
    checks++; if ((cyc - clr_cyc) !== 17) begin errors++; $display("FAIL wd_latency got=%0d exp=17 edges after CLR", cyc - clr_cyc); end
    checks++; if (busy_o !== 1'b0 || dec_en_o !== 1'b0) begin errors++; $display("FAIL wd_idle busy=%b en=%b exp 0/0", busy_o, dec_en_o); end
    repeat (3) @(negedge clk);
    checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL wd_sticky got=%b exp=1", timeout_o); end
    in_valid_i = 1'b1; in_data_i = 32'h1234_5678;
    @(negedge clk);
    in_valid_i = 1'b0;
    checks++; if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL wd_clear tmo=%b busy=%b exp 0/1", timeout_o, busy_o); end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    dec_mute = 1'b0;
  endtask
`else
  task automatic test_watchdog();
    bit ok; int th;
    for (int k = 0; k < NW; k++) sent[k] = $urandom;
    dec_mute = 1'b1;
    send_words(NW, 0, ok);
    th = 0;
    repeat (60) begin @(negedge clk); if (timeout_o) th++; end
    checks++; if (th !== 0) begin errors++; $display("FAIL nowd_timeout got=%0d exp=0", th); end
    checks++; if (busy_o !== 1'b1 || dec_en_o !== 1'b1) begin errors++; $display("FAIL nowd_waiting busy=%b en=%b exp 1/1", busy_o, dec_en_o); end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL nowd_abort busy=%b exp=0", busy_o); end
    dec_mute = 1'b0;
  endtask
`endif

  task automatic test_reset_drain();
    int n, unst; bit ok;
    for (int k = 0; k < NW; k++) sent[k] = $urandom;
    dec_err_cfg = 1'b1; dec_delay = 4;
    send_words(NW, 0, ok);
    collect_words(11, 1'b0, n, unst, ok);
    checks++; if (n !== 11 || got[10] !== (sent[10] ^ 32'hA5A5_0000)) begin errors++; $display("FAIL rd_prefix n=%0d w10=%h exp 11/%h", n, got[10], sent[10] ^ 32'hA5A5_0000); end
    @(negedge clk);
    rst_ni = 1'b0; out_ready_i = 1'b0;
    @(negedge clk);
    checks++; if (out_valid_o !== 1'b0 || out_last_o !== 1'b0 || out_err_o !== 1'b0) begin errors++; $display("FAIL rd_out valid=%b last=%b err=%b exp 0/0/0", out_valid_o, out_last_o, out_err_o); end
    checks++; if (busy_o !== 1'b0 || in_ready_o !== 1'b0 || timeout_o !== 1'b0) begin errors++; $display("FAIL rd_status busy=%b ready=%b tmo=%b exp 0/0/0", busy_o, in_ready_o, timeout_o); end
    checks++; if (dec_clrn_o !== 1'b1 || dec_en_o !== 1'b0 || dec_data_o !== '0) begin errors++; $display("FAIL rd_dec clrn=%b en=%b data0=%h exp 1/0/0", dec_clrn_o, dec_en_o, dec_data_o[31:0]); end
    rst_ni = 1'b1;
    #1;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rd_ready_after got=%b exp=1", in_ready_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort_load();
    test_abort_run();
    test_watchdog();
    test_reset_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
